// File: rtl/steer_pkg.sv
// Shared types and helpers for the steering quadrature controller.
package steer_pkg;

    // Channel FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Decoded steering direction
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CW   = 2'd1,
        CCW  = 2'd2
    } dir_t;

    // Phase index to quadrature {A,B}: 0->00, 1->01, 2->11, 3->10
    function automatic logic [1:0] gray2(input logic [1:0] idx);
        return {idx[1], idx[1] ^ idx[0]};
    endfunction

endpackage

// File: rtl/steer_chan.sv
// One steering channel: ramp FSM, rate/accel counters and quadrature phase.
// State only advances on cycles where i_tick is high.
module steer_chan
    import steer_pkg::*;
#(
    parameter int SLOW_DIV    = 4,
    parameter int FAST_DIV    = 1,
    parameter int ACCEL_STEPS = 8
) (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_tick,
    input  logic       i_enable,
    input  dir_t       i_dir,
    output logic [1:0] o_steer,
    output logic       o_step
);

    localparam int RW = $clog2(SLOW_DIV + 1);
    localparam int AW = $clog2(ACCEL_STEPS + 1);
    localparam logic [RW-1:0] SLOW_V  = RW'(SLOW_DIV);
    localparam logic [RW-1:0] FAST_V  = RW'(FAST_DIV);
    localparam logic [AW:0]   ACCEL_V = (AW + 1)'(ACCEL_STEPS);

    chan_state_t   r_state;
    dir_t          r_dir;
    logic [RW-1:0] r_ival;
    logic [RW-1:0] r_rate;
    logic [AW-1:0] r_acc;
    logic [1:0]    r_idx;
    logic [1:0]    r_steer;
    logic          r_step;

    // Increments are one bit wider so the compare can never wrap
    logic [RW:0] w_rate_inc;
    logic [AW:0] w_acc_inc;
    logic        w_rate_hit;
    logic        w_acc_hit;
    logic [1:0]  w_step_idx;

    assign w_rate_inc = {1'b0, r_rate} + (RW + 1)'(1);
    assign w_acc_inc  = {1'b0, r_acc} + (AW + 1)'(1);
    assign w_rate_hit = (w_rate_inc == {1'b0, r_ival});
    assign w_acc_hit  = (w_acc_inc == ACCEL_V);
    // In RUN the same-direction path has i_dir == r_dir, so i_dir covers every step
    assign w_step_idx = (i_dir == CCW) ? (r_idx - 2'd1) : (r_idx + 2'd1);

    // Channel FSM with ramp counters; step pulse is a single cycle
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= IDLE;
            r_dir   <= NONE;
            r_ival  <= SLOW_V;
            r_rate  <= '0;
            r_acc   <= '0;
            r_idx   <= 2'd0;
            r_steer <= 2'b00;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (i_tick) begin
                if (!i_enable || i_dir == NONE) begin
                    r_state <= IDLE;
                    r_ival  <= SLOW_V;
                    r_rate  <= '0;
                    r_acc   <= '0;
                end else if (r_state == IDLE || i_dir != r_dir) begin
                    // Fresh start or reversal: step now and restart the ramp
                    r_state <= RUN;
                    r_dir   <= i_dir;
                    r_ival  <= SLOW_V;
                    r_rate  <= '0;
                    r_acc   <= '0;
                    r_idx   <= w_step_idx;
                    r_steer <= gray2(w_step_idx);
                    r_step  <= 1'b1;
                end else if (w_rate_hit) begin
                    r_rate  <= '0;
                    r_idx   <= w_step_idx;
                    r_steer <= gray2(w_step_idx);
                    r_step  <= 1'b1;
                    if (w_acc_hit) begin
                        r_acc <= '0;
                        if (r_ival > FAST_V) begin
                            r_ival <= r_ival - RW'(1);
                        end
                    end else begin
                        r_acc <= w_acc_inc[AW-1:0];
                    end
                end else begin
                    r_rate <= w_rate_inc[RW-1:0];
                end
            end
        end
    end

    assign o_steer = r_steer;
    assign o_step  = r_step;

endmodule

// File: rtl/steer_quad_ctrl.sv
// Two-player digital steering to quadrature converter. A single prescaler
// produces ticks that are handed alternately to the two channels.
module steer_quad_ctrl
    import steer_pkg::*;
#(
    parameter int CLKDIV      = 22500,
    parameter int SLOW_DIV    = 4,
    parameter int FAST_DIV    = 1,
    parameter int ACCEL_STEPS = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enable,
    input  logic       left0,
    input  logic       right0,
    input  logic       left1,
    input  logic       right1,
    output logic [1:0] steer0,
    output logic [1:0] steer1,
    output logic       step0,
    output logic       step1
);

    localparam int PW = $clog2(CLKDIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKDIV - 1);

    logic [1:0]    r_left;
    logic [1:0]    r_right;
    logic [PW-1:0] r_presc;
    logic          r_slot;

    logic          w_presc_last;
    logic [3:0]    w_steer_bus;
    logic [1:0]    w_step_bus;

    assign w_presc_last = (r_presc == PRESC_LAST);

    // Register the joystick inputs once; index 0 is player 1
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_left  <= 2'b00;
            r_right <= 2'b00;
        end else begin
            r_left  <= {left1, left0};
            r_right <= {right1, right0};
        end
    end

    // Free-running prescaler and round-robin slot, independent of enable
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_presc <= '0;
            r_slot  <= 1'b0;
        end else if (w_presc_last) begin
            r_presc <= '0;
            r_slot  <= ~r_slot;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            dir_t w_dir;
            logic w_tick;

            assign w_tick = w_presc_last && (r_slot == 1'(gi));

            // Opposing or absent inputs decode to no motion
            always_comb begin
                w_dir = NONE;
                if (r_right[gi] && !r_left[gi]) begin
                    w_dir = CW;
                end else if (r_left[gi] && !r_right[gi]) begin
                    w_dir = CCW;
                end
            end

            steer_chan #(
                .SLOW_DIV    (SLOW_DIV),
                .FAST_DIV    (FAST_DIV),
                .ACCEL_STEPS (ACCEL_STEPS)
            ) u_chan (
                .i_clk    (CLK),
                .i_srst   (reset),
                .i_tick   (w_tick),
                .i_enable (enable),
                .i_dir    (w_dir),
                .o_steer  (w_steer_bus[2*gi +: 2]),
                .o_step   (w_step_bus[gi])
            );
        end
    endgenerate

    assign steer0 = w_steer_bus[1:0];
    assign steer1 = w_steer_bus[3:2];
    assign step0  = w_step_bus[0];
    assign step1  = w_step_bus[1];

endmodule
